// File: rtl/eth_gmii_rx_frame.sv
// GMII receive front end: strips preamble/SFD, checks the Ethernet FCS, writes frame bytes
// (FCS removed) into a byte FIFO and one 72-bit descriptor per frame into a command FIFO.
module eth_gmii_rx_frame #(
  parameter int          MAX_LEN = 1518,
  parameter int          MIN_LEN = 64,
  parameter logic [7:0]  PORT_ID = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sgmii_clk_en,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic        data_fifo_wr,
  output logic [7:0]  data_fifo_din,
  input  logic        data_fifo_afull,
  output logic        cmd_fifo_wr,
  output logic [71:0] cmd_fifo_din,
  input  logic        cmd_fifo_full,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_crc_err_cnt,
  output logic [15:0] rx_drop_cnt
);

  localparam logic [13:0] MAX_LEN_C = 14'(MAX_LEN);
  localparam logic [13:0] MIN_LEN_C = 14'(MIN_LEN);

  typedef enum logic [2:0] {IDLE, PRE, DATA, CHECK, WRITE_CMD, DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [2:0]  sr_cnt_q, sr_cnt_d;
  logic [13:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] crc_q, crc_d;
  logic        err_gmii_q, err_gmii_d;
  logic        err_len_q, err_len_d;
  logic        crc_err_q, crc_err_d;
  logic        frame_err_q, frame_err_d;
  logic [13:0] len_q, len_d;
  logic        dwr_q, dwr_d;
  logic [7:0]  ddin_q, ddin_d;
  logic        cwr_q, cwr_d;
  logic [71:0] cdin_q, cdin_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] crcerr_cnt_q, crcerr_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] fcs_calc;

  // Reflected CRC-32 (poly 0xEDB88320), one byte per call, LSB first as on the wire.
  function automatic logic [31:0] crc32_d8(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++)
      c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    return c;
  endfunction

  // Expected FCS in wire order: first received FCS byte lands in [31:24].
  assign fcs_calc = ~{crc_q[7:0], crc_q[15:8], crc_q[23:16], crc_q[31:24]};

  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    sr_cnt_d     = sr_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    crc_d        = crc_q;
    err_gmii_d   = err_gmii_q;
    err_len_d    = err_len_q;
    crc_err_d    = crc_err_q;
    frame_err_d  = frame_err_q;
    len_d        = len_q;
    dwr_d        = 1'b0;
    ddin_d       = ddin_q;
    cwr_d        = 1'b0;
    cdin_d       = cdin_q;
    frame_cnt_d  = frame_cnt_q;
    crcerr_cnt_d = crcerr_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    case (state_q)
      IDLE: begin
        if (sgmii_clk_en && gmii_rx_dv)
          state_d = (gmii_rxd == 8'h55) ? PRE : DROP;
      end
      PRE: begin
        crc_d = 32'hFFFF_FFFF;
        if (sgmii_clk_en) begin
          if (!gmii_rx_dv) begin
            state_d = IDLE;
          end else if (gmii_rxd == 8'hD5) begin
            state_d    = (!data_fifo_afull && !cmd_fifo_full) ? DATA : DROP;
            sr_cnt_d   = 3'd0;
            byte_cnt_d = 14'd0;
            err_gmii_d = 1'b0;
            err_len_d  = 1'b0;
          end else if (gmii_rxd != 8'h55) begin
            state_d = DROP;
          end
        end
      end
      DATA: begin
        if (sgmii_clk_en) begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er) err_gmii_d = 1'b1;
            if (byte_cnt_q < MAX_LEN_C) begin
              sr_d       = {sr_q[23:0], gmii_rxd};
              byte_cnt_d = byte_cnt_q + 14'd1;
              if (sr_cnt_q == 3'd4) begin
                dwr_d  = 1'b1;
                ddin_d = sr_q[31:24];
                crc_d  = crc32_d8(crc_q, sr_q[31:24]);
              end else begin
                sr_cnt_d = sr_cnt_q + 3'd1;
              end
            end else begin
              err_len_d = 1'b1;
            end
          end else begin
            state_d = CHECK;
          end
        end
      end
      CHECK: begin
        crc_err_d   = (fcs_calc != sr_q);
        len_d       = byte_cnt_q - 14'd4;
        frame_err_d = err_gmii_q | err_len_q | (byte_cnt_q < MIN_LEN_C);
        // Four bytes or fewer never left the shift register: nothing to describe.
        if (byte_cnt_q <= 14'd4) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = IDLE;
        end else begin
          state_d = WRITE_CMD;
        end
      end
      WRITE_CMD: begin
        cwr_d       = 1'b1;
        cdin_d      = {10'b0, PORT_ID, frame_err_q, crc_err_q, 38'b0, len_q};
        frame_cnt_d = frame_cnt_q + 16'd1;
        if (crc_err_q) crcerr_cnt_d = crcerr_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      DROP: begin
        if (sgmii_clk_en && !gmii_rx_dv) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      sr_cnt_q     <= '0;
      byte_cnt_q   <= '0;
      crc_q        <= '0;
      err_gmii_q   <= 1'b0;
      err_len_q    <= 1'b0;
      crc_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      len_q        <= '0;
      dwr_q        <= 1'b0;
      ddin_q       <= '0;
      cwr_q        <= 1'b0;
      cdin_q       <= '0;
      frame_cnt_q  <= '0;
      crcerr_cnt_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      sr_cnt_q     <= sr_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      crc_q        <= crc_d;
      err_gmii_q   <= err_gmii_d;
      err_len_q    <= err_len_d;
      crc_err_q    <= crc_err_d;
      frame_err_q  <= frame_err_d;
      len_q        <= len_d;
      dwr_q        <= dwr_d;
      ddin_q       <= ddin_d;
      cwr_q        <= cwr_d;
      cdin_q       <= cdin_d;
      frame_cnt_q  <= frame_cnt_d;
      crcerr_cnt_q <= crcerr_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign data_fifo_wr   = dwr_q;
  assign data_fifo_din  = ddin_q;
  assign cmd_fifo_wr    = cwr_q;
  assign cmd_fifo_din   = cdin_q;
  assign rx_frame_cnt   = frame_cnt_q;
  assign rx_crc_err_cnt = crcerr_cnt_q;
  assign rx_drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_eth_gmii_rx_frame.sv
// Directed bench for eth_gmii_rx_frame: builds wire frames with an independent MSB-first
// CRC-32 model and compares FIFO writes, descriptors, latency and counters.
module tb_eth_gmii_rx_frame;

  localparam int         MAX_LEN = 1518;
  localparam int         MIN_LEN = 64;
  localparam logic [7:0] PORT_ID = 8'h3A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sgmii_clk_en = 1'b0;
  logic [7:0]  gmii_rxd = 8'h00;
  logic        gmii_rx_dv = 1'b0;
  logic        gmii_rx_er = 1'b0;
  logic        data_fifo_wr;
  logic [7:0]  data_fifo_din;
  logic        data_fifo_afull = 1'b0;
  logic        cmd_fifo_wr;
  logic [71:0] cmd_fifo_din;
  logic        cmd_fifo_full = 1'b0;
  logic [15:0] rx_frame_cnt;
  logic [15:0] rx_crc_err_cnt;
  logic [15:0] rx_drop_cnt;

  eth_gmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN), .PORT_ID(PORT_ID)) dut (
    .clk(clk), .reset(reset), .sgmii_clk_en(sgmii_clk_en),
    .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er),
    .data_fifo_wr(data_fifo_wr), .data_fifo_din(data_fifo_din), .data_fifo_afull(data_fifo_afull),
    .cmd_fifo_wr(cmd_fifo_wr), .cmd_fifo_din(cmd_fifo_din), .cmd_fifo_full(cmd_fifo_full),
    .rx_frame_cnt(rx_frame_cnt), .rx_crc_err_cnt(rx_crc_err_cnt), .rx_drop_cnt(rx_drop_cnt)
  );

  always #4 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled 1 ns after each rising edge.
  int          cyc = 0;
  logic [7:0]  got_d[$];
  logic [71:0] got_c[$];
  int          got_c_cyc[$];
  int          dbl = 0;
  logic        prev_wr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    @(posedge clk);
    #1;
    if (data_fifo_wr) got_d.push_back(data_fifo_din);
    if (data_fifo_wr && prev_wr) dbl++;
    prev_wr = data_fifo_wr;
    if (cmd_fifo_wr) begin
      got_c.push_back(cmd_fifo_din);
      got_c_cyc.push_back(cyc);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic       toggle = 1'b0;
  logic [7:0] w [0:1699];
  int         wn;
  int         ef = 0, ec = 0, ed = 0;

  // MSB-first CRC-32 (poly 0x04C11DB7) over w[0..n-1]; returns the four FCS bytes in wire order.
  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    logic        fb;
    logic [7:0]  b0, b1, b2, b3;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) begin
        fb = c[31] ^ w[i][j];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    c = ~c;
    for (int j = 0; j < 8; j++) begin
      b0[j] = c[31 - j];
      b1[j] = c[23 - j];
      b2[j] = c[15 - j];
      b3[j] = c[7 - j];
    end
    return {b0, b1, b2, b3};
  endfunction

  task automatic gmii(input logic [7:0] d, input logic dv, input logic er);
    @(negedge clk);
    sgmii_clk_en = 1'b1;
    gmii_rxd     = d;
    gmii_rx_dv   = dv;
    gmii_rx_er   = er;
    if (toggle) begin
      @(negedge clk);
      sgmii_clk_en = 1'b0;
    end
  endtask

  task automatic send_frame(input string tag, input int ndata, input logic [7:0] bad,
                            input int er_idx, input logic afull);
    logic [31:0] f;
    int          t0, m, len, idx, n;
    logic        dropped, cerr, ferr;
    for (int i = 0; i < ndata; i++) w[i] = 8'(i * 13 + ndata);
    f = fcs_of(ndata);
    w[ndata]     = f[31:24];
    w[ndata + 1] = f[23:16];
    w[ndata + 2] = f[15:8];
    w[ndata + 3] = f[7:0] ^ bad;
    wn = ndata + 4;
    got_d.delete();
    got_c.delete();
    got_c_cyc.delete();
    data_fifo_afull = afull;
    for (int i = 0; i < 7; i++) gmii(8'h55, 1'b1, 1'b0);
    gmii(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < wn; i++) gmii(w[i], 1'b1, (i == er_idx));
    @(negedge clk);
    sgmii_clk_en = 1'b1;
    gmii_rx_dv   = 1'b0;
    gmii_rxd     = 8'h00;
    gmii_rx_er   = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    for (int i = 0; i < 12; i++) gmii(8'h00, 1'b0, 1'b0);
    data_fifo_afull = 1'b0;

    m       = (wn < MAX_LEN) ? wn : MAX_LEN;
    dropped = afull || (m <= 4);
    if (dropped) begin
      ed++;
      chk({tag, "_wrs"}, 72'(got_d.size()), 72'd0);
      chk({tag, "_cmds"}, 72'(got_c.size()), 72'd0);
    end else begin
      len  = m - 4;
      cerr = (fcs_of(len) != {w[len], w[len + 1], w[len + 2], w[len + 3]});
      ferr = (er_idx >= 0) || (wn > MAX_LEN) || (m < MIN_LEN);
      ef++;
      if (cerr) ec++;
      chk({tag, "_wrs"}, 72'(got_d.size()), 72'(len));
      n   = (got_d.size() < len) ? got_d.size() : len;
      idx = 0;
      for (int i = 0; i < n; i++)
        if (got_d[i] !== w[i]) begin
          idx = i;
          break;
        end
      if (n > 0) chk({tag, "_data"}, 72'(got_d[idx]), 72'(w[idx]));
      else       chk({tag, "_data"}, 72'h100, 72'(w[0]));
      chk({tag, "_cmds"}, 72'(got_c.size()), 72'd1);
      if (got_c.size() > 0) begin
        chk({tag, "_desc"}, got_c[0], {10'b0, PORT_ID, ferr, cerr, 38'b0, 14'(len)});
        chk({tag, "_cmd_lat"}, 72'(got_c_cyc[0]), 72'(t0 + 2));
      end
    end
    chk({tag, "_frame_cnt"}, 72'(rx_frame_cnt), 72'(ef));
    chk({tag, "_crc_cnt"}, 72'(rx_crc_err_cnt), 72'(ec));
    chk({tag, "_drop_cnt"}, 72'(rx_drop_cnt), 72'(ed));
  endtask

  int d0;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_out", {data_fifo_wr, cmd_fifo_wr, data_fifo_din, rx_frame_cnt, rx_crc_err_cnt, rx_drop_cnt}, 72'd0);
    chk("reset_desc", cmd_fifo_din, 72'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    send_frame("good60", 60, 8'h00, -1, 1'b0);
    send_frame("badfcs", 60, 8'h01, -1, 1'b0);

    toggle = 1'b1;
    d0 = dbl;
    send_frame("tog100", 96, 8'h00, -1, 1'b0);
    chk("tog100_pulse", 72'(dbl - d0), 72'd0);
    toggle = 1'b0;

    send_frame("afull", 60, 8'h00, -1, 1'b1);
    send_frame("after_afull", 60, 8'h00, -1, 1'b0);
    send_frame("rx_er", 60, 8'h00, 30, 1'b0);
    send_frame("short", 20, 8'h00, -1, 1'b0);
    send_frame("runt", 0, 8'h00, -1, 1'b0);
    send_frame("long1600", 1596, 8'h00, -1, 1'b0);

    // Reset in the middle of a frame, then a clean frame.
    for (int i = 0; i < 7; i++) gmii(8'h55, 1'b1, 1'b0);
    gmii(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) gmii(8'(i + 1), 1'b1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_out", {data_fifo_wr, cmd_fifo_wr, data_fifo_din, rx_frame_cnt, rx_crc_err_cnt, rx_drop_cnt}, 72'd0);
    gmii_rx_dv = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_hold", {data_fifo_wr, cmd_fifo_wr, data_fifo_din, rx_frame_cnt, rx_crc_err_cnt, rx_drop_cnt}, 72'd0);
    chk("midrst_desc", cmd_fifo_din, 72'd0);
    reset = 1'b0;
    ef = 0;
    ec = 0;
    ed = 0;
    repeat (2) @(negedge clk);
    send_frame("post_rst", 60, 8'h00, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
